// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled UART receiver: 2-flop rx synchronizer, 4-state FSM, registered done/error pulses
module uart_rx #(
    parameter int NBIT_DATA_LEN = 8,
    parameter int NUM_TICKS     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_tick,
    input  logic                     rx,
    output logic                     rx_done_tick,
    output logic [NBIT_DATA_LEN-1:0] data_out,
    output logic                     frame_error
);

    localparam int TW = $clog2(NUM_TICKS);
    localparam int BW = (NBIT_DATA_LEN > 1) ? $clog2(NBIT_DATA_LEN) : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(NUM_TICKS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(NUM_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NBIT_DATA_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                   state, state_n;
    logic [TW-1:0]            tick_cnt, tick_cnt_n;
    logic [BW-1:0]            bit_idx, bit_idx_n;
    logic [NBIT_DATA_LEN-1:0] shreg, shreg_n;
    logic [NBIT_DATA_LEN-1:0] data_out_n;
    logic                     rx_done_n, frame_error_n;
    logic                     rx_meta, rx_sync;

    // Synchronizer resets high so an idle line never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            data_out     <= '0;
            rx_done_tick <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_n;
            tick_cnt     <= tick_cnt_n;
            bit_idx      <= bit_idx_n;
            shreg        <= shreg_n;
            data_out     <= data_out_n;
            rx_done_tick <= rx_done_n;
            frame_error  <= frame_error_n;
        end
    end

    always_comb begin
        state_n       = state;
        tick_cnt_n    = tick_cnt;
        bit_idx_n     = bit_idx;
        shreg_n       = shreg;
        data_out_n    = data_out;
        rx_done_n     = 1'b0;
        frame_error_n = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_n    = START;
                    tick_cnt_n = '0;
                end
            end
            // Mid-start-bit check rejects glitches shorter than half a bit.
            START: begin
                if (s_tick) begin
                    if (tick_cnt == TICK_MID) begin
                        if (!rx_sync) begin
                            state_n    = DATA;
                            tick_cnt_n = '0;
                            bit_idx_n  = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        shreg_n    = {rx_sync, shreg[NBIT_DATA_LEN-1:1]};
                        tick_cnt_n = '0;
                        if (bit_idx == BIT_LAST) begin
                            state_n = STOP;
                        end else begin
                            bit_idx_n = bit_idx + BW'(1);
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + TW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        state_n = IDLE;
                        if (rx_sync) begin
                            data_out_n = shreg;
                            rx_done_n  = 1'b1;
                        end else begin
                            frame_error_n = 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + TW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx with NUM_TICKS=16, one s_tick every 4 clk
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_done_tick;
    logic [7:0] data_out;
    logic       frame_error;

    int vectors = 0;
    int miscompares = 0;

    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int wide_cnt = 0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;
    logic [7:0] rx_log[$];

    uart_rx #(
        .NBIT_DATA_LEN(8),
        .NUM_TICKS    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_tick      (s_tick),
        .rx          (rx),
        .rx_done_tick(rx_done_tick),
        .data_out    (data_out),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_cnt++;
            rx_log.push_back(data_out);
        end
        if (frame_error) err_cnt++;
        if (rx_done_tick && frame_error) both_cnt++;
        if ((rx_done_tick && prev_done) || (frame_error && prev_err)) wide_cnt++;
        prev_done = rx_done_tick;
        prev_err  = frame_error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) s_tick = 1'b1;
            @(negedge clk) s_tick = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        rx = b;
        wait_ticks(n);
    endtask

    // A bad stop bit is held low for only 12 ticks so the follow-on false start is rejected.
    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
        send_bit(stop_v, stop_v ? 16 : 12);
        rx = 1'b1;
    endtask

    initial begin
        int e0;
        int d0;

        repeat (3) @(negedge clk);
        check("reset_data_out", 32'(data_out), 32'h00);
        check("reset_done", 32'(rx_done_tick), 32'h0);
        check("reset_ferr", 32'(frame_error), 32'h0);
        reset = 1'b1;
        wait_ticks(20);

        send_frame(8'hA5, 1'b1);
        wait_ticks(20);
        check("a5_done_cnt", 32'(done_cnt), 32'd1);
        check("a5_err_cnt", 32'(err_cnt), 32'd0);
        check("a5_data_out", 32'(data_out), 32'hA5);

        send_bit(1'b0, 5);
        send_bit(1'b1, 20);
        check("false_start_done", 32'(done_cnt), 32'd1);
        check("false_start_err", 32'(err_cnt), 32'd0);
        send_frame(8'h3C, 1'b1);
        wait_ticks(20);
        check("3c_done_cnt", 32'(done_cnt), 32'd2);
        check("3c_data_out", 32'(data_out), 32'h3C);

        send_frame(8'h81, 1'b0);
        wait_ticks(20);
        check("81_err_cnt", 32'(err_cnt), 32'd1);
        check("81_done_cnt", 32'(done_cnt), 32'd2);
        check("81_data_kept", 32'(data_out), 32'h3C);

        send_frame(8'h03, 1'b1);
        send_frame(8'h05, 1'b1);
        send_frame(8'h20, 1'b1);
        wait_ticks(20);
        check("b2b_done_cnt", 32'(done_cnt), 32'd5);
        check("b2b_err_cnt", 32'(err_cnt), 32'd1);
        if (rx_log.size() >= 5) begin
            check("b2b_word0", 32'(rx_log[2]), 32'h03);
            check("b2b_word1", 32'(rx_log[3]), 32'h05);
            check("b2b_word2", 32'(rx_log[4]), 32'h20);
        end else begin
            check("b2b_log_size", 32'(rx_log.size()), 32'd5);
        end

        send_bit(1'b0, 16);
        send_bit(1'b1, 4 * 16 + 8);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_in_reset_data", 32'(data_out), 32'h00);
        reset = 1'b1;
        send_bit(1'b1, 20);
        check("abort_done_cnt", 32'(done_cnt), 32'd5);
        check("abort_err_cnt", 32'(err_cnt), 32'd1);
        check("abort_data_out", 32'(data_out), 32'h00);
        send_frame(8'h12, 1'b1);
        wait_ticks(20);
        check("12_done_cnt", 32'(done_cnt), 32'd6);
        check("12_data_out", 32'(data_out), 32'h12);

        e0 = err_cnt;
        d0 = done_cnt;
        rx = 1'b0;
        wait_ticks(3 * 160);
        check("break_err_pulses", 32'(err_cnt - e0), 32'd3);
        check("break_no_done", 32'(done_cnt - d0), 32'd0);
        reset = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_ticks(5);

        check("never_both_high", 32'(both_cnt), 32'd0);
        check("pulse_one_clk", 32'(wide_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
